// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU control blocks.
//   NREG_W     : register-address width (16 registers, R0 reads as zero)
//   fwd_sel_e  : operand-mux select encodings driven into the EX mux3to1s
//   stage_t    : destination-register info tracked per pipeline stage
package cpu_pkg;

  localparam int NREG_W = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,  // register-file value (mux d0)
    FWD_EXMEM = 2'd1,  // EX/MEM result (mux d1)
    FWD_MEMWB = 2'd2   // MEM/WB result (mux d2)
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational forwarding comparator for one source register.
//   use_src : the ID instruction actually reads src
//   src     : source register address
//   ex, mem : info of the instructions currently in EX and MEM
//   sel     : operand-mux select the ID instruction will need once it is in EX
// The instruction now in EX will be in MEM (EX/MEM result) when the reader
// reaches EX; the one now in MEM will be in WB (MEM/WB result). The newer
// producer wins when both match.
module fwd_match
  import cpu_pkg::*;
(
  input  logic              use_src,
  input  logic [NREG_W-1:0] src,
  input  stage_t            ex,
  input  stage_t            mem,
  output fwd_sel_e          sel
);

  logic ex_hit;
  logic mem_hit;
  logic unused_mem_read;

  // R0 is hardwired zero, so a write to it never produces a forwardable value.
  assign ex_hit  = ex.valid  && ex.reg_write  && (ex.rd  == src) && (ex.rd  != '0);
  assign mem_hit = mem.valid && mem.reg_write && (mem.rd == src) && (mem.rd != '0);

  // Load-ness does not affect the select; the stall logic handles loads.
  assign unused_mem_read = ex.mem_read ^ mem.mem_read;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (use_src && ex_hit) begin
      sel = FWD_EXMEM;
    end else if (use_src && mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller.
//   clk, rst                  : clock, synchronous active-high reset
//   id_valid .. id_mem_read   : decoded info of the instruction in ID
//   flush                     : branch taken, ID instruction must not enter EX
//   fwd_a_sel, fwd_b_sel      : registered EX operand-mux selects (0/1/2)
//   stall                     : combinational load-use stall for PC and IF/ID
//   stall_count               : saturating count of stall cycles
// Stage tracking always advances; on a stall or flush EX receives a bubble.
module fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rs1,
  input  logic [NREG_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  stage_t   id_info;
  stage_t   ex_q;
  stage_t   mem_q;
  stage_t   wb_q;
  fwd_sel_e a_sel_n;
  fwd_sel_e b_sel_n;
  fwd_sel_e a_sel_q;
  fwd_sel_e b_sel_q;
  logic     load_use;
  logic     bubble;
  logic     unused_wb;

  assign id_info = '{valid:     id_valid,
                     rd:        id_rd,
                     reg_write: id_reg_write,
                     mem_read:  id_mem_read};

  fwd_match u_match_a (
    .use_src (id_valid && id_use_rs1),
    .src     (id_rs1),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (a_sel_n)
  );

  fwd_match u_match_b (
    .use_src (id_valid && id_use_rs2),
    .src     (id_rs2),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (b_sel_n)
  );

  // A load in EX has no data until it leaves MEM, so a dependent reader in ID
  // must wait one cycle and then pick the value up from MEM/WB.
  assign load_use = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                    (ex_q.rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A flushed instruction is discarded anyway, so it never needs to stall.
  assign stall  = load_use && !flush;
  assign bubble = stall || flush;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      a_sel_q     <= FWD_RF;
      b_sel_q     <= FWD_RF;
      stall_count <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (bubble) begin
        ex_q    <= '0;
        a_sel_q <= FWD_RF;
        b_sel_q <= FWD_RF;
      end else begin
        ex_q    <= id_info;
        a_sel_q <= a_sel_n;
        b_sel_q <= b_sel_n;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // WB is tracked for pipeline visibility; WB-to-ID hazards are resolved by
  // the register file writing before it is read.
  assign unused_wb = ^wb_q;

  assign fwd_a_sel = a_sel_q;
  assign fwd_b_sel = b_sel_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: a table of per-cycle ID inputs with
// hand-computed stall (same cycle) and selects/count (after the edge), plus
// hand-written reset and counter-saturation sequences. A second instance with
// a 2-bit counter shares all inputs.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, s_a_sel, s_b_sel;
  logic       stall, s_stall;
  logic [15:0] stall_count;
  logic [1:0]  s_stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .stall_count(stall_count)
  );

  fwd_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(s_a_sel), .fwd_b_sel(s_b_sel),
    .stall(s_stall), .stall_count(s_stall_count)
  );

  typedef struct {
    logic       valid;
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] rd;
    logic       rw, mr, fl;
    logic       exp_stall;
    logic [1:0] exp_a, exp_b;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(logic [3:0] rs1, logic [3:0] rs2, logic u1, logic u2,
                              logic [3:0] rd, logic rw, logic mr, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb, logic [15:0] ec);
    vec_t r;
    r.valid = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl;
    r.exp_stall = es; r.exp_a = ea; r.exp_b = eb; r.exp_cnt = ec;
    return r;
  endfunction

  // Inputs change 1 ns after a rising edge; stall is sampled on the falling
  // edge, registered outputs 1 ns after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rs1 rs2 u1 u2 rd  rw mr fl  stall a  b  cnt
    vecs[0]  = mk(0, 0, 0, 0, 3,  1, 0, 0,  0, 0, 0, 0);  // write r3
    vecs[1]  = mk(3, 3, 1, 0, 8,  1, 0, 0,  0, 1, 0, 0);  // back-to-back read r3; rs2 unused
    vecs[2]  = mk(0, 0, 0, 0, 5,  1, 0, 0,  0, 0, 0, 0);  // write r5
    vecs[3]  = mk(1, 0, 1, 0, 9,  1, 0, 0,  0, 0, 0, 0);  // independent, writes r9
    vecs[4]  = mk(9, 5, 1, 1, 10, 1, 0, 0,  0, 1, 2, 0);  // r9 from EX/MEM, r5 from MEM/WB
    vecs[5]  = mk(0, 0, 0, 0, 4,  1, 0, 0,  0, 0, 0, 0);  // write r4
    vecs[6]  = mk(0, 0, 0, 0, 4,  1, 0, 0,  0, 0, 0, 0);  // write r4 again
    vecs[7]  = mk(4, 0, 1, 0, 0,  0, 0, 0,  0, 1, 0, 0);  // newest r4 wins
    vecs[8]  = mk(0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);  // write r0
    vecs[9]  = mk(0, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0, 0);  // read r0: never forwarded
    vecs[10] = mk(0, 0, 0, 0, 7,  1, 1, 0,  0, 0, 0, 0);  // load r7
    vecs[11] = mk(7, 0, 1, 0, 11, 1, 0, 0,  1, 0, 0, 1);  // load-use: stall, bubble
    vecs[12] = mk(7, 0, 1, 0, 11, 1, 0, 0,  0, 2, 0, 1);  // held reader: from MEM/WB
    vecs[13] = mk(0, 0, 0, 0, 6,  1, 1, 0,  0, 0, 0, 1);  // load r6
    vecs[14] = mk(0, 6, 0, 1, 0,  0, 0, 1,  0, 0, 0, 1);  // load-use but flushed
    vecs[15] = mk(0, 6, 0, 1, 0,  0, 0, 0,  0, 0, 2, 1);  // load now in MEM, EX was bubble

    rst = 1'b1;
    idle();
    cycle();
    cycle();
    check("reset_a_sel", 32'(fwd_a_sel), 0);
    check("reset_b_sel", 32'(fwd_b_sel), 0);
    check("reset_count", 32'(stall_count), 0);
    check("reset_stall", 32'(stall), 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      cycle();
      check($sformatf("v%0d_a_sel", i), 32'(fwd_a_sel), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_b_sel", i), 32'(fwd_b_sel), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_count", i), 32'(stall_count), 32'(vecs[i].exp_cnt));
    end

    // Reset while a load to r12 sits in EX and its reader is in ID.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 4'd12, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_a_sel", 32'(fwd_a_sel), 0);
    check("rst_mid_b_sel", 32'(fwd_b_sel), 0);
    check("rst_mid_count", 32'(stall_count), 0);
    check("rst_mid_sat_count", 32'(s_stall_count), 0);
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 0);
    cycle();
    check("rst_post_a_sel", 32'(fwd_a_sel), 0);
    check("rst_post_b_sel", 32'(fwd_b_sel), 0);

    // Four load-use stalls: 16-bit counter reaches 4, 2-bit counter holds at 3.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("sat%0d_stall", k), 32'(s_stall), 1);
      cycle();
      @(negedge clk);
      check($sformatf("sat%0d_no_restall", k), 32'(stall), 0);
      cycle();
      check($sformatf("sat%0d_a_sel", k), 32'(fwd_a_sel), 2);
      if (k == 2) check("sat_count_at3", 32'(s_stall_count), 3);
    end
    check("sat_count_wide", 32'(stall_count), 4);
    check("sat_count_held", 32'(s_stall_count), 3);

    idle();
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 16-bit pipelined CPU. It tracks destination-register information from the ID stage through the EX, MEM and WB stages. It drives the 2-bit select inputs of the two EX-stage `mux3to1` operand multiplexers. It also raises a one-cycle stall on load-use hazards and counts stalls for performance monitoring.

## Interface
- `NREG_W`, 4: register-address width (16 architectural registers; R0 hardwired zero).
- `CNT_W`, 16: stall-counter width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  NREG_W  source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  the instruction actually reads that source.
- `id_rd`  in  NREG_W  destination register.
- `id_reg_write`  in  1  the instruction writes `id_rd`.
- `id_mem_read`  in  1  the instruction is a load.
- `flush`  in  1  branch taken; the ID instruction must not enter EX.
- `fwd_a_sel`, `fwd_b_sel`  out  2  select for the operand A/B muxes: 0 = register-file value (d0), 1 = EX/MEM result (d1), 2 = MEM/WB result (d2); 3 is never driven.
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- Internal stage registers: EX {valid, rd, reg_write, mem_read}, MEM {valid, rd, reg_write}, WB {valid, rd, reg_write}. They advance every cycle; the module itself is never held.
- Producer match (per source s ∈ {rs1, rs2}): a stage with valid & reg_write & rd==s & rd≠0.
- Select computed at the edge moving ID→EX, then registered:
  - If the current EX stage matches (it becomes MEM next cycle): sel = 1.
  - Else if the current MEM stage matches (it becomes WB): sel = 2.
  - Otherwise sel = 0.
  - When `id_use_sN`=0, sel = 0 for that operand.
- EX/MEM priority over MEM/WB: the newest value wins.
- `stall` = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd≠0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)) & !flush.
- Stall cycle:
  - EX loads a bubble (valid=0, reg_write=0, mem_read=0); both sel outputs load 0.
  - MEM and WB advance normally.
  - Next cycle the held instruction re-evaluates; the load is now in MEM, so it gets sel = 2 and no stall.
- Flush cycle: EX loads a bubble; sels load 0. Flush overrides stall, so `stall`=0 when both conditions hold.
- `stall_count` increments by 1 on each cycle with `stall`=1 and saturates at all-ones.
- WB→ID same-cycle hazards are the register file's responsibility (write-before-read); they are not forwarded here.

## Timing
- Reset (`rst`=1 at an edge):
  - All stage valids, reg_writes and mem_reads clear to 0.
  - `fwd_a_sel` = `fwd_b_sel` = 0; `stall_count` = 0.
  - `stall` is 0 from the first post-reset cycle, because EX.valid=0.
- Reset mid-operation discards all in-flight tracking immediately.
- Sel outputs are registered and valid for the entire cycle the instruction occupies EX, i.e. one cycle after it was presented in ID.
- `stall` is combinational and valid in the same cycle as the ID inputs.
- The pipeline control must gate IF/ID with it before the edge.

## Structure
- Shared package `cpu_pkg`:
  - `NREG_W`
  - select encodings `FWD_RF`=0, `FWD_EXMEM`=1, `FWD_MEMWB`=2
  - stage-info struct {valid, rd, reg_write, mem_read}
- One natural sub-module: `fwd_match`, a combinational comparator returning the 2-bit select for one source register. Two instances, one per operand.
- The stage registers and stall counter are implemented in the top module.

## Test plan
- Back-to-back ALU ops:
  - Cycle 0: ID rd=3 with reg_write.
  - Cycle 1: ID rs1=3.
  - Required: `fwd_a_sel`=1 in cycle 2 and `stall`=0.
- Distance-two dependency:
  - Write r5, then an independent op, then an op reading rs2=5.
  - Required: `fwd_b_sel`=2 when the reader is in EX.
- Double producer:
  - Write r4 twice consecutively, then read rs1=4.
  - Required: `fwd_a_sel`=1 (newest wins), not 2.
- Load-use:
  - Load rd=7, then an op reading rs1=7.
  - Required: `stall`=1 for exactly one cycle; EX bubble with sels 0; next cycle `fwd_a_sel`=2; `stall_count`=1.
- R0 and flush:
  - Write r0, then read rs1=0: `fwd_a_sel`=0.
  - Load-use condition with `flush`=1: `stall`=0, EX bubble, `stall_count` unchanged.
- Reset mid-stream:
  - Assert `rst` while a dependency is in flight.
  - Required: next-cycle sels=0, `stall`=0, `stall_count`=0, and no forwarding from pre-reset producers.
  - With `CNT_W`=2, four forced stalls give `stall_count`=3 (saturated).
